// File: rtl/vreduce_seq.sv
// Sequential FP16 vector reducer: accumulates a stream of elements through an external 2-cycle adder.
// Optional macro VREDUCE_NAN_SKIP_EN: once the accumulator holds a NaN, remaining elements bypass the adder.
module vreduce_seq #(
   parameter int CNT_W = 8
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [15:0]      in_data,
   input  logic             in_last,
   output logic             add_en,
   output logic [15:0]      add_a,
   output logic [15:0]      add_b,
   input  logic [15:0]      add_out,
   input  logic             add_ovf,
   input  logic             add_valid,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [15:0]      res_data,
   output logic             res_ovf,
   output logic [CNT_W-1:0] res_count
);

   typedef enum logic [1:0] {IDLE, GATHER, WAIT, DONE} state_t;

   state_t             state_q, state_d;
   logic [15:0]        acc_q, acc_d;
   logic [CNT_W-1:0]   count_q, count_d, count_inc;
   logic               ovf_q, ovf_d;
   logic               last_q, last_d;
   logic               acc_nan;

`ifdef VREDUCE_NAN_SKIP_EN
   assign acc_nan = (acc_q[14:10] == 5'h1F) && (acc_q[9:0] != 10'h000);
`else
   assign acc_nan = 1'b0;
`endif

   assign count_inc = (count_q == {CNT_W{1'b1}}) ? count_q : count_q + CNT_W'(1);

   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      last_d   = last_q;
      in_ready = (state_q == IDLE) || (state_q == GATHER);
      add_en   = 1'b0;
      add_a    = 16'h0000;
      add_b    = 16'h0000;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               acc_d   = in_data;
               count_d = CNT_W'(1);
               ovf_d   = 1'b0;
               state_d = in_last ? DONE : GATHER;
            end
         end
         GATHER: begin
            if (in_valid) begin
               count_d = count_inc;
               if (acc_nan) begin
                  state_d = in_last ? DONE : GATHER;
               end else begin
                  add_en  = 1'b1;
                  add_a   = acc_q;
                  add_b   = in_data;
                  last_d  = in_last;
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            // Results landing in any other state are stale issues and are dropped.
            if (add_valid) begin
               acc_d   = add_out;
               ovf_d   = ovf_q | add_ovf;
               state_d = last_q ? DONE : GATHER;
            end
         end
         DONE: begin
            if (res_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
         acc_q   <= 16'h0000;
         count_q <= '0;
         ovf_q   <= 1'b0;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
         last_q  <= last_d;
      end
   end

   assign res_valid = (state_q == DONE);
   assign res_data  = res_valid ? acc_q : 16'h0000;
   assign res_ovf   = res_valid & ovf_q;
   assign res_count = res_valid ? count_q : '0;

endmodule

// File: tb/tb_vreduce_seq.sv
// Bench for vreduce_seq: table of vectors through a behavioural 2-cycle FP16 adder, with a result scoreboard.
module tb_vreduce_seq;

   localparam int CNT_W = 3;
`ifdef VREDUCE_NAN_SKIP_EN
   localparam int NAN_PULSES = 0;
`else
   localparam int NAN_PULSES = 2;
`endif

   logic             CLK = 1'b0;
   logic             RST = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [15:0]      in_data = 16'h0000;
   logic             in_last = 1'b0;
   logic             add_en;
   logic [15:0]      add_a, add_b, add_out;
   logic             add_ovf, add_valid;
   logic             res_valid;
   logic             res_ready = 1'b0;
   logic [15:0]      res_data;
   logic             res_ovf;
   logic [CNT_W-1:0] res_count;

   int total = 0;
   int bad = 0;
   int pulses = 0;
   logic [15:0] model_acc = 16'h0000;

   typedef struct {
      int          n;
      logic [15:0] e [10];
      logic [15:0] data;
      logic        ovf;
      int          count;
      int          pulses;
   } vec_t;

   typedef struct {
      logic [15:0] data;
      logic        ovf;
      int          count;
      int          pulses;
   } exp_t;

   vec_t vecs [7];
   exp_t sb_q [$];

   vreduce_seq #(.CNT_W(CNT_W)) dut (
      .CLK(CLK), .RST(RST),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
      .add_en(add_en), .add_a(add_a), .add_b(add_b),
      .add_out(add_out), .add_ovf(add_ovf), .add_valid(add_valid),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
      .res_ovf(res_ovf), .res_count(res_count)
   );

   always #5 CLK = ~CLK;

   // Positive-only truncating FP16 add, enough for the vectors used here; returns {ovf, sum}.
   function automatic logic [16:0] fp_add(input logic [15:0] a, input logic [15:0] b);
      int          ea, eb, sh;
      logic [11:0] ma, mb, s, t;
      if (a[14:10] == 5'h1F) return {1'b0, a};
      if (b[14:10] == 5'h1F) return {1'b0, b};
      if (a == 16'h0000) return {1'b0, b};
      if (b == 16'h0000) return {1'b0, a};
      ea = int'(a[14:10]);
      eb = int'(b[14:10]);
      ma = {2'b01, a[9:0]};
      mb = {2'b01, b[9:0]};
      if (ea < eb) begin
         t = ma; ma = mb; mb = t;
         sh = ea; ea = eb; eb = sh;
      end
      mb = mb >> (ea - eb);
      s  = ma + mb;
      if (s[11]) begin
         s  = s >> 1;
         ea = ea + 1;
      end
      if (ea >= 31) return {1'b1, 16'h7C00};
      return {1'b0, 1'b0, 5'(ea), s[9:0]};
   endfunction

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural adder: operands sampled mid-cycle, result presented two cycles after the issue cycle.
   logic        en_s = 1'b0;
   logic [16:0] res_s = 17'h0;
   logic        p1_v = 1'b0, p2_v = 1'b0;
   logic [16:0] p1_r = 17'h0, p2_r = 17'h0;

   always @(negedge CLK) begin
      en_s  = add_en;
      res_s = fp_add(add_a, add_b);
      if (add_en) begin
         pulses++;
         check_output("add_b_operand", 32'(add_b), 32'(in_data));
         check_output("add_a_operand", 32'(add_a), 32'(model_acc));
         model_acc = fp_add(model_acc, in_data) & 17'h0FFFF;
      end else begin
         check_output("add_idle_zero", {add_a, add_b}, 32'h0);
      end
   end

   always @(posedge CLK) begin
      p1_v <= en_s;
      p1_r <= res_s;
      p2_v <= p1_v;
      p2_r <= p1_r;
   end

   assign add_valid = p2_v;
   assign add_out   = p2_r[15:0];
   assign add_ovf   = p2_r[16];

   // Offers one element starting just after a rising edge; returns just after the accepting edge.
   task automatic send(input logic [15:0] d, input logic last, input logic first);
      int guard = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      if (first) model_acc = d;
      @(negedge CLK);
      while (!in_ready && guard < 50) begin
         @(negedge CLK);
         guard++;
      end
      check_output("in_ready_timeout", 32'(in_ready), 32'h1);
      @(posedge CLK);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic collect(input int hold);
      int   guard = 0;
      exp_t ex;
      @(negedge CLK);
      while (!res_valid && guard < 100) begin
         @(negedge CLK);
         guard++;
      end
      if (!res_valid) begin
         check_output("res_valid_timeout", 32'(res_valid), 32'h1);
         if (sb_q.size() > 0) void'(sb_q.pop_front());
      end else begin
         ex = sb_q.pop_front();
         check_output("res_data", 32'(res_data), 32'(ex.data));
         check_output("res_ovf", 32'(res_ovf), 32'(ex.ovf));
         check_output("res_count", 32'(res_count), 32'(ex.count));
         check_output("add_en_pulses", 32'(pulses), 32'(ex.pulses));
         check_output("done_in_ready", 32'(in_ready), 32'h0);
         for (int h = 0; h < hold; h++) begin
            @(negedge CLK);
            check_output("hold_res_valid", 32'(res_valid), 32'h1);
            check_output("hold_res_data", 32'(res_data), 32'(ex.data));
            check_output("hold_res_count", 32'(res_count), 32'(ex.count));
            check_output("hold_in_ready", 32'(in_ready), 32'h0);
         end
         res_ready = 1'b1;
         @(posedge CLK);
         #1;
         res_ready = 1'b0;
         @(negedge CLK);
         check_output("post_done_res_valid", 32'(res_valid), 32'h0);
         check_output("post_done_in_ready", 32'(in_ready), 32'h1);
      end
      @(posedge CLK);
      #1;
   endtask

   task automatic apply_stimulus(input int idx);
      exp_t ex;
      ex.data   = vecs[idx].data;
      ex.ovf    = vecs[idx].ovf;
      ex.count  = vecs[idx].count;
      ex.pulses = vecs[idx].pulses;
      sb_q.push_back(ex);
      pulses = 0;
      for (int i = 0; i < vecs[idx].n; i++) begin
         send(vecs[idx].e[i], (i == vecs[idx].n - 1), (i == 0));
      end
      collect(0);
   endtask

   task automatic check_reset_outputs();
      check_output("rst_res_valid", 32'(res_valid), 32'h0);
      check_output("rst_add_en", 32'(add_en), 32'h0);
      check_output("rst_res_data", 32'(res_data), 32'h0);
      check_output("rst_res_ovf", 32'(res_ovf), 32'h0);
      check_output("rst_res_count", 32'(res_count), 32'h0);
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish, bad=%0d", bad);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      exp_t ex;
      vecs[0] = '{3,  '{16'h3C00, 16'h4000, 16'h3800, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0}, 16'h4300, 1'b0, 3, 2};
      vecs[1] = '{1,  '{16'h4000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0}, 16'h4000, 1'b0, 1, 0};
      vecs[2] = '{2,  '{16'h7BFF, 16'h7BFF, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0}, 16'h7C00, 1'b1, 2, 1};
      vecs[3] = '{4,  '{16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0}, 16'h4400, 1'b0, 4, 3};
      vecs[4] = '{3,  '{16'h7E00, 16'h3C00, 16'h3C00, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0}, 16'h7E00, 1'b0, 3, NAN_PULSES};
      vecs[5] = '{10, '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0}, 16'h0000, 1'b0, 7, 9};
      vecs[6] = '{2,  '{16'h3C00, 16'h4000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0}, 16'h4200, 1'b0, 2, 1};

      repeat (3) @(posedge CLK);
      @(negedge CLK);
      check_reset_outputs();
      @(posedge CLK);
      #1;
      RST = 1'b0;
      @(negedge CLK);
      check_reset_outputs();
      check_output("rst_in_ready", 32'(in_ready), 32'h1);
      @(posedge CLK);
      #1;

      for (int v = 0; v < 6; v++) begin
         apply_stimulus(v);
      end

      // Element spacing after a GATHER accept, then a result held back for five cycles.
      ex = '{16'h4400, 1'b0, 3, 2};
      sb_q.push_back(ex);
      pulses = 0;
      send(16'h3C00, 1'b0, 1'b1);
      send(16'h3C00, 1'b0, 1'b0);
      @(negedge CLK);
      check_output("wait1_in_ready", 32'(in_ready), 32'h0);
      @(negedge CLK);
      check_output("wait2_in_ready", 32'(in_ready), 32'h0);
      @(negedge CLK);
      check_output("gather_in_ready", 32'(in_ready), 32'h1);
      @(posedge CLK);
      #1;
      send(16'h4000, 1'b1, 1'b0);
      collect(5);

      // Reset while waiting on the adder; its late result must be discarded.
      send(16'h3C00, 1'b0, 1'b1);
      send(16'h3C00, 1'b0, 1'b0);
      RST = 1'b1;
      @(posedge CLK);
      #1;
      RST = 1'b0;
      @(negedge CLK);
      check_reset_outputs();
      check_output("late_in_ready", 32'(in_ready), 32'h1);
      check_output("late_add_out", 32'(add_out), 32'h4000);
      @(negedge CLK);
      check_output("late_res_valid", 32'(res_valid), 32'h0);
      check_output("late_idle_ready", 32'(in_ready), 32'h1);
      @(posedge CLK);
      #1;
      apply_stimulus(6);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
